booth_mul_pipe: RTL
===================

Name: booth_mul_pipe

Overview:
- Parametrised radix-4 Booth / carry-save-tree multiplier with configurable register depth, replacing the fixed 32-bit two-stage multiplier in the EX/MEM path.
- Adds a valid/ready handshake on both sides, whole-pipe backpressure, a flush input and a tag pass-through, so the pipeline control can hold or kill multiplies on stalls and exceptions.
- Serves MULT/MULTU (HI/LO write) and any future MUL-class instructions.

Parameters:
- WIDTH, 32: operand width; must be even and >= 8; result is 2*WIDTH.
- PIPE_STAGES, 2: register stages between operand accept and result; legal range 1..4; equals the unstalled latency.
- TAG_W, 5: width of the opaque tag carried with each operation.

Ports:
- mul_clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- mul_flush  in  1  kills every in-flight operation.
- in_valid  in  1  operand set presented.
- in_ready  out  1  block can accept this cycle.
- mul_signed  in  1  1 = signed x signed; 0 = unsigned x unsigned.
- x  in  WIDTH  multiplicand.
- y  in  WIDTH  multiplier.
- in_tag  in  TAG_W  tag travelling with the operation.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes the result.
- result  out  2*WIDTH  product.
- out_tag  out  TAG_W  tag of the op in `result`.

Behaviour:
- Accept: an operation is accepted on an edge where in_valid & in_ready & !mul_flush.
- in_ready = !mul_flush & (!out_valid | out_ready). This is a single global stall: all stages advance together or hold together.
- Latency: with no stall, an op accepted at edge N gives out_valid=1 after edge N+PIPE_STAGES. Throughput is one op per cycle.
- Operand extension: each operand is extended to WIDTH+2 bits, using the sign bit when mul_signed=1 and zero otherwise.
- Partial products: WIDTH/2+1 Booth partial products (0, ±X, ±2X), each sign-extended to 2*WIDTH.
- Reduction: 3:2 CSA tree, then a final carry-propagate add. Result = exact product mod 2^(2*WIDTH).
- Register placement: the tree is split into PIPE_STAGES register boundaries. Stage k holds a valid bit, the tag and the CSA sum/carry vectors. The last stage holds the final `result`.
- Stall: while out_valid=1 and out_ready=0, every stage holds. result, out_tag and out_valid stay stable. There is no loss and no duplication.
- Handoff: when out_valid & out_ready, the next op moves up in the same edge. If none is behind it, out_valid drops.
- Flush: mul_flush=1 clears all valid bits at that edge. out_valid=0 from the next cycle. An op presented in the flush cycle is not accepted. mul_flush has priority over out_ready: a result visible in the flush cycle counts as consumed only if out_ready=1 in that same cycle; otherwise it is dropped.
- Reset: resetn=0 at any edge, including mid-operation, clears all valid bits, result to 0 and out_tag to 0. in_ready is 0 during reset and 1 in the first cycle after reset if mul_flush=0.
- Datapath registers with valid=0 hold zero, to match the reset image and reduce switching.
- mul_signed is sampled only at accept and travels with the op. It may change freely between ops.

Optional Feature:
- Macro: MUL_MAC_EN.
- When defined:
  - Adds port acc_in (in, 2*WIDTH) and port mac (in, 1), both sampled at accept.
  - When mac=1, acc_in is injected as one extra CSA operand, so result = x*y + acc_in mod 2^(2*WIDTH).
  - Latency is unchanged.
- When undefined:
  - The ports do not exist.
  - The behaviour is a plain multiply.

Test Plan:
- Extremes (WIDTH=32, PIPE_STAGES=2, out_ready=1):
  - signed -1 x -1 -> 0x0000000000000001.
  - unsigned 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE00000001.
  - signed 0x80000000 x 0x80000000 -> 0x4000000000000000.
  - Each result appears 2 cycles after accept.
- Streaming: 4 back-to-back ops (3x7, signed -5x9, 0x10000x0x10000, 0x0), tags 1..4 -> out_valid for 4 consecutive cycles with results 21, 0xFFFFFFFFFFFFFFD3, 0x100000000, 0 and out_tag 1..4 in order.
- Backpressure: hold out_ready=0 for 5 cycles while feeding ops -> in_ready falls once the pipe is full, result/out_tag stay stable, and after release every accepted op appears exactly once, in order.
- Flush: accept tags 6 and 7, assert mul_flush one cycle later -> neither result appears; a new op (2x3, tag 8) accepted the cycle after the flush -> result 6 with tag 8.
- Reset mid-op: accept an op, drop resetn for 1 cycle -> out_valid=0, result=0, no stale output afterward. Repeat with WIDTH=16, PIPE_STAGES=1: signed 0x8000 x 0x7FFF -> 0xC0008000 after 1 cycle.
- With MUL_MAC_EN: 3x5 with mac=1, acc_in=10 -> 25. Unsigned 0xFFFFFFFF x 1 with acc_in=0xFFFFFFFF00000001 -> 0x0000000000000000 (wraps). mac=0 ignores acc_in.

Source files
------------

// File: rtl/booth_mul_pipe_if.sv
// Operand/result handshake bundle for booth_mul_pipe.
// master = issuing pipeline control, slave = the multiplier.
// With MUL_MAC_EN defined the bundle also carries acc_in and mac.
interface booth_mul_pipe_if #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
);
  logic                 mul_flush;
  logic                 in_valid;
  logic                 in_ready;
  logic                 mul_signed;
  logic [WIDTH-1:0]     x;
  logic [WIDTH-1:0]     y;
  logic [TAG_W-1:0]     in_tag;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   result;
  logic [TAG_W-1:0]     out_tag;
`ifdef MUL_MAC_EN
  logic [2*WIDTH-1:0]   acc_in;
  logic                 mac;

  modport master (
    output mul_flush, in_valid, mul_signed, x, y, in_tag, out_ready, acc_in, mac,
    input  in_ready, out_valid, result, out_tag
  );
  modport slave (
    input  mul_flush, in_valid, mul_signed, x, y, in_tag, out_ready, acc_in, mac,
    output in_ready, out_valid, result, out_tag
  );
`else
  modport master (
    output mul_flush, in_valid, mul_signed, x, y, in_tag, out_ready,
    input  in_ready, out_valid, result, out_tag
  );
  modport slave (
    input  mul_flush, in_valid, mul_signed, x, y, in_tag, out_ready,
    output in_ready, out_valid, result, out_tag
  );
`endif
endinterface

// File: rtl/booth_mul_pipe.sv
// Pipelined radix-4 Booth multiplier with carry-save reduction.
// Operands are captured in an input register at accept, followed by
// PIPE_STAGES register stages; the last stage holds the final product.
// The whole pipe advances or holds together (single global stall).
// Optional feature: define MUL_MAC_EN to add acc_in/mac (result = x*y + acc_in).
module booth_mul_pipe #(
  parameter int WIDTH       = 32,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 5
) (
  input logic                mul_clk,
  input logic                resetn,
  booth_mul_pipe_if.slave    mul
);
  localparam int W2  = 2 * WIDTH;
  localparam int XW  = WIDTH + 2;
  localparam int NPP = WIDTH / 2 + 1;
`ifdef MUL_MAC_EN
  localparam int NOPS = NPP + 1;
`else
  localparam int NOPS = NPP;
`endif

  typedef struct packed {
    logic             v;
    logic             sgn;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
`ifdef MUL_MAC_EN
    logic             mac;
    logic [W2-1:0]    acc;
`endif
  } opnd_t;

  typedef struct packed {
    logic             v;
    logic [TAG_W-1:0] tag;
    logic [W2-1:0]    sum;
    logic [W2-1:0]    carry;
  } stage_t;

  opnd_t         op_q, op_d;
  stage_t        st_q [PIPE_STAGES];
  stage_t        st_d [PIPE_STAGES];
  logic [W2-1:0] tree_sum, tree_carry;
  logic          advance;

  // The pipe may move whenever the output slot is empty or being consumed.
  assign advance       = !st_q[PIPE_STAGES-1].v || mul.out_ready;
  assign mul.in_ready  = resetn && !mul.mul_flush && advance;
  assign mul.out_valid = st_q[PIPE_STAGES-1].v;
  assign mul.result    = st_q[PIPE_STAGES-1].sum;
  assign mul.out_tag   = st_q[PIPE_STAGES-1].tag;

  // Build the operand-register image; an empty slot is all zeros.
  always_comb begin
    op_d = '0;
    if (mul.in_valid) begin
      op_d.v   = 1'b1;
      op_d.sgn = mul.mul_signed;
      op_d.tag = mul.in_tag;
      op_d.x   = mul.x;
      op_d.y   = mul.y;
`ifdef MUL_MAC_EN
      op_d.mac = mul.mac;
      op_d.acc = mul.acc_in;
`endif
    end
  end

  // Booth recoding of the captured operands and 3:2 carry-save reduction
  // down to one sum/carry pair.
  always_comb begin : booth_tree
    logic [XW-1:0] xe, ye;
    logic [XW:0]   yb;
    logic [W2-1:0] mx, pp, a, b, c;
    logic [2:0]    grp;
    logic [W2-1:0] lvl [NOPS];
    logic [W2-1:0] nxt [NOPS];
    int            cnt, n, groups;
    // NOTE: blocking assignments here model combinational temporaries;
    // every variable gets a value before any use, so no latch is inferred.
    xe = op_q.sgn ? {{2{op_q.x[WIDTH-1]}}, op_q.x} : {2'b00, op_q.x};
    ye = op_q.sgn ? {{2{op_q.y[WIDTH-1]}}, op_q.y} : {2'b00, op_q.y};
    yb = {ye, 1'b0};
    mx = {{(W2-XW){xe[XW-1]}}, xe};
    pp = '0;
    a = '0; b = '0; c = '0;
    grp = '0;
    for (int i = 0; i < NOPS; i++) begin
      lvl[i] = '0;
      nxt[i] = '0;
    end
    for (int i = 0; i < NPP; i++) begin
      grp = yb[2*i +: 3];
      case (grp)
        3'b001, 3'b010: pp = mx;
        3'b011:         pp = mx << 1;
        3'b100:         pp = -(mx << 1);
        3'b101, 3'b110: pp = -mx;
        default:        pp = '0;
      endcase
      lvl[i] = pp << (2 * i);
    end
`ifdef MUL_MAC_EN
    lvl[NPP] = op_q.mac ? op_q.acc : '0;
`endif
    cnt = NOPS;
    for (int l = 0; l < NOPS; l++) begin
      if (cnt > 2) begin
        n      = 0;
        groups = cnt / 3;
        for (int j = 0; j < NOPS; j++) nxt[j] = '0;
        for (int g = 0; g < NOPS; g++) begin
          if (g < groups) begin
            a = lvl[3*g];
            b = lvl[3*g+1];
            c = lvl[3*g+2];
            nxt[n]   = a ^ b ^ c;
            nxt[n+1] = ((a & b) | (a & c) | (b & c)) << 1;
            n = n + 2;
          end
        end
        for (int r = 0; r < NOPS; r++) begin
          if (r >= groups * 3 && r < cnt) begin
            nxt[n] = lvl[r];
            n = n + 1;
          end
        end
        lvl = nxt;
        cnt = n;
      end
    end
    tree_sum   = lvl[0];
    tree_carry = lvl[1];
  end

  // Next image of each stage; the last stage resolves sum+carry into the product.
  always_comb begin
    stage_t src;
    for (int k = 0; k < PIPE_STAGES; k++) begin
      if (k == 0) begin
        src.v     = op_q.v;
        src.tag   = op_q.tag;
        src.sum   = tree_sum;
        src.carry = tree_carry;
      end else begin
        src = st_q[(k > 0) ? k - 1 : 0];
      end
      st_d[k] = src;
      if (k == PIPE_STAGES - 1) begin
        st_d[k].sum   = src.sum + src.carry;
        st_d[k].carry = '0;
      end
    end
  end

  // Pipeline registers: reset and flush empty every stage, otherwise all
  // stages advance together or hold together.
  always_ff @(posedge mul_clk) begin
    // NOTE: datapath registers are cleared alongside the valid bits so an
    // empty slot always reads as zero, matching the reset image.
    if (!resetn || mul.mul_flush) begin
      op_q <= '0;
      for (int k = 0; k < PIPE_STAGES; k++) st_q[k] <= '0;
    end else if (advance) begin
      op_q <= op_d;
      for (int k = 0; k < PIPE_STAGES; k++) st_q[k] <= st_d[k];
    end
  end
endmodule
